// File: rtl/mpt_pkg.sv
// Shared types and field positions for the memory-protection-table walker.
// Index fields are fixed at PA[33:12] regardless of the physical address width.
package mpt_pkg;

    typedef enum logic [1:0] {
        ACC_R    = 2'b00,
        ACC_W    = 2'b01,
        ACC_X    = 2'b10,
        ACC_RSVD = 2'b11
    } acc_type_e;

    typedef enum logic [1:0] {
        CAUSE_ALLOW   = 2'b00,
        CAUSE_DENIED  = 2'b01,
        CAUSE_INVALID = 2'b10,
        CAUSE_BUS_ERR = 2'b11
    } cause_e;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        L1_REQ  = 3'd1,
        L1_WAIT = 3'd2,
        L2_REQ  = 3'd3,
        L2_WAIT = 3'd4,
        RESP    = 3'd5,
        DRAIN   = 3'd6
    } state_e;

    localparam int L1_LSB = 25;
    localparam int L1_W   = 9;
    localparam int L2_LSB = 16;
    localparam int L2_W   = 9;
    localparam int PG_LSB = 12;
    localparam int PG_W   = 4;
    localparam int NB_LSB = 10;

    typedef struct packed {
        acc_type_e       acc;
        logic [L1_W-1:0] l1;
        logic [L2_W-1:0] l2;
        logic [PG_W-1:0] page;
    } mpt_req_t;

    typedef struct packed {
        logic       err;
        logic       v;
        logic       leaf;
        logic [2:0] xwr;
    } mpt_rsp_t;

    // Root entry low bits: bit0 V, bit1 LEAF, bits[4:2] {X,W,R}.
    function automatic mpt_rsp_t decode_root(input logic [4:0] lo, input logic err);
        mpt_rsp_t r;
        r.err  = err;
        r.v    = lo[0];
        r.leaf = lo[1];
        r.xwr  = lo[4:2];
        return r;
    endfunction

endpackage

// File: rtl/mpt_perm_check.sv
// Combinational permission check: selects the R/W/X bit for the access type.
// The reserved access type never matches a permission and is always denied.
module mpt_perm_check
    import mpt_pkg::*;
(
    input  logic [2:0] xwr,
    input  acc_type_e  acc,
    output cause_e     cause
);

    always_comb begin
        cause = CAUSE_DENIED;
        case (acc)
            ACC_R:   if (xwr[0]) cause = CAUSE_ALLOW;
            ACC_W:   if (xwr[1]) cause = CAUSE_ALLOW;
            ACC_X:   if (xwr[2]) cause = CAUSE_ALLOW;
            default: cause = CAUSE_DENIED;
        endcase
    end

endmodule

// File: rtl/mpt_walker.sv
// Two-level memory-protection-table walker: one request in flight, one table read port,
// allow/fault verdict toward the next pipeline register under stall/flush control.
module mpt_walker
    import mpt_pkg::*;
#(
    parameter int PA_WIDTH       = 34,
    parameter int MEM_DATA_WIDTH = 64
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      mpt_en_i,
    input  logic [PA_WIDTH-1:0]       mpt_base_i,
    input  logic                      s_data_valid,
    output logic                      s_data_ready,
    input  logic [PA_WIDTH+1:0]       s_data_rdata,
    output logic                      m_data_valid,
    input  logic                      m_data_ready,
    output logic [PA_WIDTH+1:0]       m_data_rdata,
    output logic                      m_mem_valid,
    input  logic                      m_mem_ready,
    output logic [PA_WIDTH-1:0]       m_mem_addr,
    input  logic                      s_mem_valid,
    input  logic [MEM_DATA_WIDTH-1:0] s_mem_rdata,
    input  logic                      s_mem_err,
    input  logic                      s_ctrl_stall,
    input  logic                      s_ctrl_flush
);

    state_e              state_q, state_d;
    mpt_req_t            req_in, req_q;
    logic [PA_WIDTH-1:0] pa_q;
    logic [PA_WIDTH-1:0] base_q;
    cause_e              cause_q;

    logic                accept;
    logic                rsp_take;
    mpt_rsp_t            rsp;
    logic [2:0]          xwr_sel;
    cause_e              perm_cause;
    cause_e              walk_cause;
    logic [PA_WIDTH-1:0] next_base;
    logic [PA_WIDTH-1:0] idx_off;

    always_comb begin
        req_in.acc  = acc_type_e'(s_data_rdata[PA_WIDTH +: 2]);
        req_in.l1   = s_data_rdata[L1_LSB +: L1_W];
        req_in.l2   = s_data_rdata[L2_LSB +: L2_W];
        req_in.page = s_data_rdata[PG_LSB +: PG_W];
    end

    assign accept   = (state_q == IDLE) && s_data_valid && s_data_ready;
    assign rsp_take = s_mem_valid && !s_ctrl_flush;

    // Response decode: root bits when walking L1, the page nibble when walking L2.
    assign rsp       = decode_root(s_mem_rdata[4:0], s_mem_err);
    assign xwr_sel   = (state_q == L1_WAIT) ? rsp.xwr
                                            : s_mem_rdata[{req_q.page, 2'b00} +: 3];
    assign next_base = {s_mem_rdata[NB_LSB +: PA_WIDTH-12], 12'h000};

    mpt_perm_check u_perm (
        .xwr   (xwr_sel),
        .acc   (req_q.acc),
        .cause (perm_cause)
    );

    always_comb begin
        walk_cause = perm_cause;
        if (rsp.err)
            walk_cause = CAUSE_BUS_ERR;
        else if ((state_q == L1_WAIT) && !rsp.v)
            walk_cause = CAUSE_INVALID;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = mpt_en_i ? L1_REQ : RESP;
            L1_REQ:  if (s_ctrl_flush) state_d = IDLE;
                     else if (m_mem_ready) state_d = L1_WAIT;
            L2_REQ:  if (s_ctrl_flush) state_d = IDLE;
                     else if (m_mem_ready) state_d = L2_WAIT;
            L1_WAIT: begin
                if (s_ctrl_flush)
                    state_d = s_mem_valid ? IDLE : DRAIN;
                else if (s_mem_valid)
                    state_d = (!rsp.err && rsp.v && !rsp.leaf) ? L2_REQ : RESP;
            end
            L2_WAIT: begin
                if (s_ctrl_flush)
                    state_d = s_mem_valid ? IDLE : DRAIN;
                else if (s_mem_valid)
                    state_d = RESP;
            end
            RESP:    if (s_ctrl_flush || (m_data_valid && m_data_ready)) state_d = IDLE;
            DRAIN:   if (s_mem_valid) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Request / walk registers: no reset, every output use is qualified by state.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            req_q   <= req_in;
            pa_q    <= s_data_rdata[PA_WIDTH-1:0];
            base_q  <= mpt_base_i;
            cause_q <= CAUSE_ALLOW;
        end else if ((state_q == L1_WAIT) && rsp_take) begin
            base_q  <= next_base;
            cause_q <= walk_cause;
        end else if ((state_q == L2_WAIT) && rsp_take) begin
            cause_q <= walk_cause;
        end
    end

    assign idx_off = PA_WIDTH'({(state_q == L1_REQ) ? req_q.l1 : req_q.l2, 3'b000});

    // Output stage: flush forces everything low in the same cycle.
    assign s_data_ready = rst_ni && (state_q == IDLE) && !s_ctrl_stall && !s_ctrl_flush;
    assign m_mem_valid  = ((state_q == L1_REQ) || (state_q == L2_REQ)) && !s_ctrl_flush;
    assign m_mem_addr   = m_mem_valid ? (base_q + idx_off) : '0;
    assign m_data_valid = (state_q == RESP) && !s_ctrl_stall && !s_ctrl_flush;
    assign m_data_rdata = ((state_q == RESP) && !s_ctrl_flush) ? {cause_q, pa_q} : '0;

endmodule

// File: tb/tb_mpt_walker.sv
// Directed bench for mpt_walker: table reads are served by hand with known entries.
module tb_mpt_walker;

    localparam int PA_W = 34;

    logic            clk_i = 1'b0;
    logic            rst_ni;
    logic            mpt_en_i;
    logic [PA_W-1:0] mpt_base_i;
    logic            s_data_valid;
    logic            s_data_ready;
    logic [PA_W+1:0] s_data_rdata;
    logic            m_data_valid;
    logic            m_data_ready;
    logic [PA_W+1:0] m_data_rdata;
    logic            m_mem_valid;
    logic            m_mem_ready;
    logic [PA_W-1:0] m_mem_addr;
    logic            s_mem_valid;
    logic [63:0]     s_mem_rdata;
    logic            s_mem_err;
    logic            s_ctrl_stall;
    logic            s_ctrl_flush;

    int nvec = 0;
    int nmis = 0;

    always #5 clk_i = ~clk_i;

    mpt_walker #(.PA_WIDTH(PA_W), .MEM_DATA_WIDTH(64)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .mpt_en_i     (mpt_en_i),
        .mpt_base_i   (mpt_base_i),
        .s_data_valid (s_data_valid),
        .s_data_ready (s_data_ready),
        .s_data_rdata (s_data_rdata),
        .m_data_valid (m_data_valid),
        .m_data_ready (m_data_ready),
        .m_data_rdata (m_data_rdata),
        .m_mem_valid  (m_mem_valid),
        .m_mem_ready  (m_mem_ready),
        .m_mem_addr   (m_mem_addr),
        .s_mem_valid  (s_mem_valid),
        .s_mem_rdata  (s_mem_rdata),
        .s_mem_err    (s_mem_err),
        .s_ctrl_stall (s_ctrl_stall),
        .s_ctrl_flush (s_ctrl_flush)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [1:0] acc, input logic [PA_W-1:0] pa, input string tag);
        int n = 0;
        @(negedge clk_i);
        s_data_valid = 1'b1;
        s_data_rdata = {acc, pa};
        #1;
        while (!s_data_ready && n < 40) begin
            @(negedge clk_i); #1; n++;
        end
        chk({tag, "_rdy"}, s_data_ready, 1);
        @(posedge clk_i); #1;
        s_data_valid = 1'b0;
    endtask

    task automatic serve_req(input logic [PA_W-1:0] exp_addr, input string tag);
        int n = 0;
        @(negedge clk_i);
        while (!m_mem_valid && n < 40) begin
            @(negedge clk_i); n++;
        end
        chk({tag, "_mvld"}, m_mem_valid, 1);
        chk({tag, "_addr"}, m_mem_addr, exp_addr);
        m_mem_ready = 1'b1;
        @(posedge clk_i); #1;
        m_mem_ready = 1'b0;
    endtask

    task automatic serve_rsp(input logic [63:0] data, input logic err);
        @(negedge clk_i);
        s_mem_valid = 1'b1;
        s_mem_rdata = data;
        s_mem_err   = err;
        @(posedge clk_i); #1;
        s_mem_valid = 1'b0;
        s_mem_err   = 1'b0;
        s_mem_rdata = '0;
    endtask

    task automatic serve(input logic [PA_W-1:0] exp_addr, input logic [63:0] data,
                         input logic err, input string tag);
        serve_req(exp_addr, tag);
        serve_rsp(data, err);
    endtask

    task automatic verdict(input logic [1:0] cause, input logic [PA_W-1:0] pa, input string tag);
        int n = 0;
        @(negedge clk_i);
        while (!m_data_valid && n < 40) begin
            @(negedge clk_i); n++;
        end
        chk({tag, "_dvld"}, m_data_valid, 1);
        chk({tag, "_verdict"}, m_data_rdata, {cause, pa});
        m_data_ready = 1'b1;
        @(posedge clk_i); #1;
        m_data_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_ni = 1'b0; mpt_en_i = 1'b0; mpt_base_i = '0;
        s_data_valid = 1'b0; s_data_rdata = '0; m_data_ready = 1'b0;
        m_mem_ready = 1'b0; s_mem_valid = 1'b0; s_mem_rdata = '0; s_mem_err = 1'b0;
        s_ctrl_stall = 1'b0; s_ctrl_flush = 1'b0;

        // Reset values and IDLE readiness under stall/flush
        #12;
        chk("rst_sready", s_data_ready, 0);
        chk("rst_dvalid", m_data_valid, 0);
        chk("rst_drdata", m_data_rdata, 0);
        chk("rst_mvalid", m_mem_valid, 0);
        chk("rst_maddr",  m_mem_addr, 0);
        @(negedge clk_i); rst_ni = 1'b1; #1;
        chk("idle_rdy", s_data_ready, 1);
        s_ctrl_flush = 1'b1; #1;
        chk("idle_flush_rdy", s_data_ready, 0);
        s_ctrl_flush = 1'b0; s_ctrl_stall = 1'b1; #1;
        chk("idle_stall_rdy", s_data_ready, 0);
        s_ctrl_stall = 1'b0;

        // Bypass: allowed one cycle after acceptance, no table read
        mpt_en_i = 1'b0;
        send(2'b00, 34'h0_1234_5000, "byp");
        @(negedge clk_i);
        chk("byp_lat", m_data_valid, 1);
        chk("byp_nomem", m_mem_valid, 0);
        verdict(2'b00, 34'h0_1234_5000, "byp");

        // Root leaf, W permitted (V=1, LEAF=1, W=1 -> 0xB)
        mpt_en_i = 1'b1; mpt_base_i = 34'h1000;
        send(2'b01, 34'h0_0200_0000, "rleaf");
        serve(34'h1008, 64'hB, 1'b0, "rleaf_l1");
        verdict(2'b00, 34'h0_0200_0000, "rleaf");

        // Two-level walk, R on an X-only page -> denied
        send(2'b00, 34'h0_0001_3000, "two");
        serve(34'h1000, 64'h801, 1'b0, "two_l1");
        serve(34'h2008, 64'h4000, 1'b0, "two_l2");
        verdict(2'b01, 34'h0_0001_3000, "two");

        // Two-level walk, W on page 5 with W set -> allowed
        send(2'b01, 34'h0_0005_5000, "twow");
        serve(34'h1000, 64'h801, 1'b0, "twow_l1");
        serve(34'h2028, 64'h20_0000, 1'b0, "twow_l2");
        verdict(2'b00, 34'h0_0005_5000, "twow");

        // Root V=0 (0x6) -> invalid entry
        send(2'b00, 34'h0_0400_0000, "inv");
        serve(34'h1010, 64'h6, 1'b0, "inv_l1");
        verdict(2'b10, 34'h0_0400_0000, "inv");

        // Bus error on the leaf read
        send(2'b01, 34'h0_0001_3000, "berr");
        serve(34'h1000, 64'h801, 1'b0, "berr_l1");
        serve(34'h2008, 64'h0, 1'b1, "berr_l2");
        verdict(2'b11, 34'h0_0001_3000, "berr");

        // Reserved access type with full permissions -> denied
        send(2'b11, 34'h0_0200_0000, "rsvd");
        serve(34'h1008, 64'h1F, 1'b0, "rsvd_l1");
        verdict(2'b01, 34'h0_0200_0000, "rsvd");

        // Flush during L2_WAIT, then drain the late response
        send(2'b00, 34'h0_0001_3000, "fl");
        serve(34'h1000, 64'h801, 1'b0, "fl_l1");
        serve_req(34'h2008, "fl_l2");
        s_data_valid = 1'b1; s_data_rdata = {2'b00, 34'h0_0001_3000};
        s_ctrl_flush = 1'b1; #1;
        chk("fl_sready", s_data_ready, 0);
        chk("fl_mvalid", m_mem_valid, 0);
        chk("fl_maddr",  m_mem_addr, 0);
        chk("fl_dvalid", m_data_valid, 0);
        chk("fl_drdata", m_data_rdata, 0);
        @(posedge clk_i); #1;
        s_ctrl_flush = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            chk("drain_sready", s_data_ready, 0);
        end
        s_data_valid = 1'b0;
        serve_rsp(64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        @(negedge clk_i);
        chk("drain_done_rdy", s_data_ready, 1);
        chk("drain_no_verdict", m_data_valid, 0);
        send(2'b00, 34'h0_0001_3000, "post");
        serve(34'h1000, 64'h801, 1'b0, "post_l1");
        serve(34'h2008, 64'h1000, 1'b0, "post_l2");
        verdict(2'b00, 34'h0_0001_3000, "post");

        // Backpressure in RESP with a stall pulse in the middle
        mpt_en_i = 1'b0;
        send(2'b10, 34'h3_0000_0ABC, "bp");
        for (int i = 0; i < 5; i++) begin
            s_ctrl_stall = (i == 2);
            @(negedge clk_i);
            chk("bp_dvalid", m_data_valid, (i == 2) ? 1'b0 : 1'b1);
            chk("bp_drdata", m_data_rdata, {2'b00, 34'h3_0000_0ABC});
            @(posedge clk_i); #1;
        end
        s_ctrl_stall = 1'b0;
        verdict(2'b00, 34'h3_0000_0ABC, "bp");

        // Flush while a verdict is pending
        send(2'b00, 34'h0_0000_1000, "frs");
        s_ctrl_flush = 1'b1; #1;
        chk("frs_dvalid", m_data_valid, 0);
        chk("frs_drdata", m_data_rdata, 0);
        @(posedge clk_i); #1;
        s_ctrl_flush = 1'b0;
        @(negedge clk_i);
        chk("frs_idle_rdy", s_data_ready, 1);
        chk("frs_gone", m_data_valid, 0);

        // Asynchronous reset mid-walk, then a stray response is ignored
        mpt_en_i = 1'b1;
        send(2'b00, 34'h0_0001_3000, "ar");
        @(negedge clk_i);
        chk("ar_mvalid_pre", m_mem_valid, 1);
        #2 rst_ni = 1'b0; #1;
        chk("ar_mvalid", m_mem_valid, 0);
        chk("ar_maddr",  m_mem_addr, 0);
        chk("ar_sready", s_data_ready, 0);
        @(negedge clk_i); rst_ni = 1'b1;
        serve_rsp(64'h801, 1'b0);
        @(negedge clk_i);
        chk("ar_stray_dvalid", m_data_valid, 0);
        chk("ar_stray_mvalid", m_mem_valid, 0);
        chk("ar_stray_rdy", s_data_ready, 1);
        send(2'b10, 34'h0_0200_0000, "arx");
        serve(34'h1008, 64'h13, 1'b0, "arx_l1");
        verdict(2'b00, 34'h0_0200_0000, "arx");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
